ctrl_reencoder: RTL
===================

# ctrl_reencoder

Registered reverse decoder for the main control bundle. Each valid cycle it samples the nine single-bit control signals from the main controller and re-encodes them into the originating instruction class and MIPS opcode. It keeps saturating per-class counters and raises a sticky error, with the offending word captured, on any combination the controller must never produce. It sits beside the controller as an on-line checker and as the encoder-side counterpart used by the control testbenches.

## Interface
- CNT_W, 16, width of each per-class counter
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  qualifies the control bundle this cycle
- RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, ALUOP1, ALUOP2  in  1 each  control bundle
- err_clear  in  1  clears the sticky error and the captured word
- cnt_clear  in  1  zeroes all counters
- cnt_sel  in  3  selects the counter driven on cnt_out (class code)
- out_valid  out  1  registered in_valid
- cls  out  3  decoded class code
- opcode  out  6  re-encoded opcode
- illegal  out  1  current output word is illegal
- err  out  1  sticky error
- err_word  out  9  first illegal bundle {RegDst,ALUSrc,MemToReg,RegWrite,MemRead,MemWrite,Branch,ALUOP1,ALUOP2}
- cnt_out  out  CNT_W  registered value of the selected counter

## Operation
- Classes (code / opcode / required bits; bits not listed are don't-care):
  - 0 RTYPE / 000000: RegDst=1 ALUSrc=0 MemToReg=0 RegWrite=1 MemRead=0 MemWrite=0 Branch=0 ALUOP1=1 ALUOP2=0
  - 1 LOAD / 100011: RegDst=0 ALUSrc=1 MemToReg=1 RegWrite=1 MemRead=1 MemWrite=0 Branch=0 ALUOP=00
  - 2 STORE / 101011: ALUSrc=1 RegWrite=0 MemRead=0 MemWrite=1 Branch=0 ALUOP=00; RegDst and MemToReg are ignored
  - 3 BRANCH / 000100: ALUSrc=0 RegWrite=0 MemRead=0 MemWrite=0 Branch=1 ALUOP1=0 ALUOP2=1; RegDst and MemToReg are ignored
  - 4 IDLE / 111111: all nine bits 0, the controller's response to unsupported opcodes
  - 5 ILLEGAL / 111111: any other combination. illegal=1.
- Match priority RTYPE > LOAD > STORE > BRANCH > IDLE. The class patterns are mutually exclusive, so the priority only fixes the implementation structure.
- Counters: six CNT_W-bit counters, one per class 0–5. When in_valid=1 the counter for the decoded class increments by 1 and saturates at all-ones; it does not wrap.
- Sticky error:
  - On a valid ILLEGAL sample with err=0: err←1 and err_word←bundle.
  - Later illegal samples do not overwrite err_word.
- Simultaneous events:
  - err_clear with a valid ILLEGAL sample in the same cycle: err←1 and err_word←the new bundle (new event wins).
  - cnt_clear with a valid sample in the same cycle: all counters ←0, and the sample is not counted (clear wins).
- cnt_sel values 6 and 7 return 0.
- in_valid=0: cls, opcode and illegal hold their last values; counters and error state are unchanged.

## Timing
- Decode latency is 1 cycle: a bundle sampled at edge N appears on out_valid, cls, opcode and illegal after edge N.
- Counter update lands at edge N. cnt_out registers the selected counter at edge N+1, so a sample is visible on cnt_out 2 edges after it is taken.
- err and err_word update at edge N, visible the same cycle as illegal.
- Reset, applied on any edge and including mid-stream: out_valid=0, cls=4, opcode=111111, illegal=0, err=0, err_word=0, all counters=0, cnt_out=0. reset overrides every other input.
- No back-pressure: one bundle is accepted every cycle.

## Test plan
- R-type bundle {1,0,0,1,0,0,0,1,0} valid for 3 cycles, cnt_sel=0 → cls=0, opcode=000000, illegal=0; cnt_out reads 3 two cycles after the last sample.
- Load {0,1,1,1,1,0,0,0,0}, store {1,1,0,0,0,1,0,0,0} and {0,1,1,0,0,1,0,0,0}, branch {0,0,1,0,0,0,1,0,1}, then all-zero → opcodes 100011, 101011 (twice), 000100, 111111; the STORE counter reads 2.
- Illegal {0,0,0,1,1,1,0,0,0} followed by a second illegal {1,1,1,1,1,1,1,1,1} → err=1, err_word=000111000 after the first sample and unchanged after the second; the ILLEGAL counter reads 2.
- err_clear asserted together with a valid illegal {1,0,0,0,0,0,0,0,0} → err stays 1 and err_word=100000000. err_clear alone on the next cycle → err=0, err_word=0.
- CNT_W=4 with 20 R-type samples → RTYPE counter reads 15 (saturated). cnt_clear together with one more R-type sample → counter reads 0.
- reset asserted mid-stream with err=1 and nonzero counters → on the next cycle every output is at its reset value. Decoding resumes correctly on the first valid sample after reset.

Source files
------------

// File: rtl/ctrl_reencoder.sv
// ctrl_reencoder: registered reverse decoder for the main control bundle.
// Re-encodes the nine control bits into instruction class and MIPS opcode.
// Keeps saturating per-class counters. Raises a sticky error and captures
// the first bundle the controller should never produce.
module ctrl_reencoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             RegDst,
    input  logic             ALUSrc,
    input  logic             MemToReg,
    input  logic             RegWrite,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic             Branch,
    input  logic             ALUOP1,
    input  logic             ALUOP2,
    input  logic             err_clear,
    input  logic             cnt_clear,
    input  logic [2:0]       cnt_sel,
    output logic             out_valid,
    output logic [2:0]       cls,
    output logic [5:0]       opcode,
    output logic             illegal,
    output logic             err,
    output logic [8:0]       err_word,
    output logic [CNT_W-1:0] cnt_out
);

    typedef enum logic [2:0] {
        CLS_RTYPE   = 3'd0,
        CLS_LOAD    = 3'd1,
        CLS_STORE   = 3'd2,
        CLS_BRANCH  = 3'd3,
        CLS_IDLE    = 3'd4,
        CLS_ILLEGAL = 3'd5
    } cls_e;

    localparam int NUM_CLS = 6;

    // Bit 8 is RegDst, bit 0 is ALUOP2.
    // STORE and BRANCH ignore RegDst (bit 8) and MemToReg (bit 6).
    localparam logic [8:0] PAT_RTYPE  = 9'b100100010;
    localparam logic [8:0] PAT_LOAD   = 9'b011110000;
    localparam logic [8:0] MASK_SB    = 9'b010111111;
    localparam logic [8:0] PAT_STORE  = 9'b010001000;
    localparam logic [8:0] PAT_BRANCH = 9'b000000101;

    logic [8:0] bundle;
    assign bundle = {RegDst, ALUSrc, MemToReg, RegWrite, MemRead,
                     MemWrite, Branch, ALUOP1, ALUOP2};

    cls_e       dec_cls;
    logic [5:0] dec_opcode;
    logic       dec_illegal;

    logic [CNT_W-1:0] cnt [NUM_CLS];

    // Decode the bundle into class and opcode, in priority order.
    always_comb begin
        // NOTE: defaults are assigned first so that every path drives
        // every output, which keeps this block free of latches.
        dec_cls    = CLS_ILLEGAL;
        dec_opcode = 6'b111111;
        if (bundle == PAT_RTYPE) begin
            dec_cls    = CLS_RTYPE;
            dec_opcode = 6'b000000;
        end else if (bundle == PAT_LOAD) begin
            dec_cls    = CLS_LOAD;
            dec_opcode = 6'b100011;
        end else if ((bundle & MASK_SB) == PAT_STORE) begin
            dec_cls    = CLS_STORE;
            dec_opcode = 6'b101011;
        end else if ((bundle & MASK_SB) == PAT_BRANCH) begin
            dec_cls    = CLS_BRANCH;
            dec_opcode = 6'b000100;
        end else if (bundle == 9'd0) begin
            dec_cls    = CLS_IDLE;
            dec_opcode = 6'b111111;
        end
        dec_illegal = (dec_cls == CLS_ILLEGAL);
    end

    // Register the decoded word. It holds its value while in_valid is low.
    always_ff @(posedge clk) begin
        // NOTE: state is written with non-blocking assignments so that
        // every flop samples values from before the edge.
        if (reset) begin
            out_valid <= 1'b0;
            cls       <= CLS_IDLE;
            opcode    <= 6'b111111;
            illegal   <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                cls     <= dec_cls;
                opcode  <= dec_opcode;
                illegal <= dec_illegal;
            end
        end
    end

    // Sticky error. A new illegal sample always wins over err_clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            err      <= 1'b0;
            err_word <= 9'd0;
        end else if (in_valid && dec_illegal && (!err || err_clear)) begin
            err      <= 1'b1;
            err_word <= bundle;
        end else if (err_clear) begin
            err      <= 1'b0;
            err_word <= 9'd0;
        end
    end

    // Per-class saturating counters. cnt_clear wins over a same-cycle sample.
    always_ff @(posedge clk) begin
        // NOTE: this array is a set of flops rather than a RAM, so it is
        // safe to reset every entry.
        if (reset || cnt_clear) begin
            for (int i = 0; i < NUM_CLS; i++) begin
                cnt[i] <= '0;
            end
        end else if (in_valid) begin
            for (int i = 0; i < NUM_CLS; i++) begin
                if ((dec_cls == cls_e'(i)) && (cnt[i] != '1)) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Register the selected counter. Codes 6 and 7 read as zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_out <= '0;
        end else begin
            case (cnt_sel)
                3'd0:    cnt_out <= cnt[0];
                3'd1:    cnt_out <= cnt[1];
                3'd2:    cnt_out <= cnt[2];
                3'd3:    cnt_out <= cnt[3];
                3'd4:    cnt_out <= cnt[4];
                3'd5:    cnt_out <= cnt[5];
                default: cnt_out <= '0;
            endcase
        end
    end

endmodule
